// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared states, ratio limits and helpers for the clock-divider controller
package clkdiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam int DIV_MIN = 2;
  localparam int DIV_2MHZ = 8;
  localparam int DIV_1MHZ = 16;
  function automatic int unsigned hi_len(input int unsigned div);
    return (div + 1) >> 1;
  endfunction
endpackage

// File: rtl/clkdiv_if.sv
// clkdiv_if: ratio configuration handshake
interface clkdiv_if #(parameter int DIV_W = 8);
  logic cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic cfg_ready;
  logic cfg_err;
  modport master(output cfg_valid, cfg_div, input cfg_ready, cfg_err);
  modport slave(input cfg_valid, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clkdiv_period_cnt.sv
// clkdiv_period_cnt: period counter with wrap detect and next-cycle high-phase compare
module clkdiv_period_cnt
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk16MHz,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] cnt,
  output logic             wrap,
  output logic             hi
);
  logic [DIV_W-1:0] cnt_nxt;
  // hi refers to the count about to be loaded; at a wrap that count is 0,
  // which is high under any legal ratio, so a ratio swap cannot glitch it
  always_comb begin
    wrap = en && (cnt == div - DIV_W'(1));
    cnt_nxt = (en && !wrap) ? cnt + DIV_W'(1) : '0;
    hi = 32'(cnt_nxt) < hi_len(32'(div));
  end
  always_ff @(posedge clk16MHz or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= cnt_nxt;
endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run/stop FSM, ratio handshake and registered divided clock with tick
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int DEFAULT_DIV = DIV_2MHZ
) (
  input  logic     clk16MHz,
  input  logic     reset,
  input  logic     run_en,
  clkdiv_if.slave  cfg,
  output logic     clk_out,
  output logic     tick,
  output logic     busy
);
  state_t state, state_nxt;
  logic [DIV_W-1:0] div_cur, div_nxt, div_pend, cnt;
  logic pend, pend_nxt, wrap, hi, busy_nxt, acc, bad, apply_now;
  clkdiv_period_cnt #(.DIV_W(DIV_W)) u_cnt (
    .clk16MHz,
    .reset,
    .en(busy),
    .div(div_cur),
    .cnt,
    .wrap,
    .hi
  );
  assign busy = state != IDLE;
  assign cfg.cfg_ready = !pend;
  // a ratio accepted while idle or on a wrap takes effect immediately; otherwise it waits
  always_comb begin
    bad = cfg.cfg_valid && !pend && cfg.cfg_div < DIV_W'(DIV_MIN);
    acc = cfg.cfg_valid && !pend && !bad;
    apply_now = acc && (!busy || wrap);
    state_nxt = run_en ? RUN : (state == IDLE || wrap) ? IDLE : STOP;
    busy_nxt = state_nxt != IDLE;
    div_nxt = apply_now ? cfg.cfg_div : (wrap && pend) ? div_pend : div_cur;
    pend_nxt = (acc && !apply_now) || (pend && !wrap);
  end
  always_ff @(posedge clk16MHz or negedge reset)
    if (!reset) begin
      state <= IDLE;
      div_cur <= DIV_W'(DEFAULT_DIV);
      div_pend <= '0;
      pend <= 1'b0;
      clk_out <= 1'b0;
      tick <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      state <= state_nxt;
      div_cur <= div_nxt;
      pend <= pend_nxt;
      if (acc) div_pend <= cfg.cfg_div;
      clk_out <= busy_nxt && hi;
      tick <= busy_nxt && (busy ? wrap : cnt == '0);
      cfg.cfg_err <= bad;
    end
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed and randomized stimulus against a period-position reference model
module tb_clkdiv_ctrl;
  logic clk16MHz = 1'b0;
  logic reset = 1'b1;
  logic run_en = 1'b0;
  logic clk_out, tick, busy;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_act;
  int m_pos, m_ratio, m_q;
  bit m_err;

  clkdiv_if #(.DIV_W(8)) cfg();
  clkdiv_ctrl #(.DIV_W(8), .DEFAULT_DIV(8)) dut (
    .clk16MHz(clk16MHz),
    .reset(reset),
    .run_en(run_en),
    .cfg(cfg),
    .clk_out(clk_out),
    .tick(tick),
    .busy(busy)
  );

  always #5 clk16MHz = ~clk16MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_act = 0; m_pos = 0; m_ratio = 8; m_q = 0; m_err = 0;
  endtask

  // model: position inside the current period, active ratio, queued ratio (0 = none)
  task automatic m_step(input bit run, input bit v, input int d);
    bit acc, last;
    last = m_act && m_pos == m_ratio - 1;
    acc = v && m_q == 0 && d >= 2;
    m_err = v && m_q == 0 && d < 2;
    if (!m_act) begin
      if (acc) m_ratio = d;
      m_act = run;
      m_pos = 0;
    end else if (last) begin
      if (acc) m_ratio = d;
      else if (m_q != 0) m_ratio = m_q;
      m_q = 0;
      m_act = run;
      m_pos = 0;
    end else begin
      if (acc) m_q = d;
      m_pos++;
    end
  endtask

  task automatic check_all();
    chk("clk_out", clk_out, m_act && m_pos < (m_ratio + 1) / 2);
    chk("tick", tick, m_act && m_pos == 0);
    chk("busy", busy, m_act);
    chk("cfg_ready", cfg.cfg_ready, m_q == 0);
    chk("cfg_err", cfg.cfg_err, m_err);
  endtask

  task automatic cyc(input bit run, input bit v, input int d);
    run_en = run;
    cfg.cfg_valid = v;
    cfg.cfg_div = d[7:0];
    @(posedge clk16MHz);
    m_step(run, v, d);
    #1;
    check_all();
  endtask

  task automatic run_to(input bit run, input int pos);
    for (int i = 0; i < 300 && !(m_act && m_pos == pos); i++) cyc(run, 0, 0);
  endtask

  task automatic run_n(input bit run, input int n);
    for (int i = 0; i < n; i++) cyc(run, 0, 0);
  endtask

  task automatic go_idle();
    for (int i = 0; i < 300 && m_act; i++) cyc(0, 0, 0);
  endtask

  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div = '0;
    m_reset();
    #1 reset = 1'b0;
    #1 check_all();
    @(negedge clk16MHz);
    @(negedge clk16MHz);
    reset = 1'b1;
    cyc(0, 0, 0);
    run_n(1, 20);
    run_to(1, 3);
    cyc(1, 1, 16);
    run_n(1, 40);
    cyc(1, 1, 5);
    run_n(1, 25);
    cyc(1, 1, 1);
    cyc(1, 1, 0);
    run_n(1, 12);
    cyc(1, 1, 8);
    run_n(1, 10);
    run_to(1, 2);
    go_idle();
    run_n(0, 3);
    run_to(1, 2);
    run_to(0, 5);
    run_n(1, 20);
    run_to(1, 2);
    cyc(1, 1, 16);
    cyc(1, 0, 0);
    #2 reset = 1'b0;
    m_reset();
    #1 check_all();
    @(negedge clk16MHz);
    reset = 1'b1;
    run_n(1, 20);
    go_idle();
    cyc(1, 1, 3);
    run_n(1, 10);
    go_idle();
    cyc(0, 1, 2);
    run_n(1, 8);
    cyc(0, 1, 255);
    go_idle();
    cyc(0, 1, 7);
    run_n(1, 16);
    for (int i = 0; i < 3000; i++) begin
      bit r, v;
      if ($urandom_range(0, 15) == 0) r = !run_en;
      else r = run_en;
      v = $urandom_range(0, 3) == 0;
      cyc(r, v, int'($urandom_range(0, 12)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Programmable clock-divider controller for the 16 MHz domain. It holds the active divide ratio and starts and stops the divided output on whole-period boundaries. A valid/ready port accepts new ratios and applies them glitch-free at the next period wrap. It sits beside the fixed divider and generates the run-time-selectable rates (e.g. 2 MHz, 1 MHz) plus a one-cycle `tick` enable for downstream logic.

## Interface
- `DIV_W`, 8: width of the divide-ratio field.
- `DEFAULT_DIV`, 8: ratio loaded at reset (16 MHz / 8 = 2 MHz).
- `clk16MHz`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `run_en`  input  1  level request to produce the divided clock.
- `cfg_valid`  input  1  new ratio offered.
- `cfg_div`  input  DIV_W  offered ratio N; legal range 2..2^DIV_W-1.
- `cfg_ready`  output  1  controller can accept a ratio.
- `cfg_err`  output  1  one-cycle pulse: illegal ratio rejected.
- `clk_out`  output  1  divided clock, registered.
- `tick`  output  1  one-cycle pulse on each `clk_out` rising edge.
- `busy`  output  1  high in RUN or STOP.

## Operation
- States:
  - IDLE: output parked low.
  - RUN: free-running divide.
  - STOP: finishing the current period after `run_en` falls.
- Separate `pend` flag plus `div_pend` register hold an accepted ratio awaiting a wrap.
- Counter `cnt` (DIV_W bits) counts 0..div_cur-1 in RUN and STOP.
  - "Wrap cycle" is `cnt == div_cur-1`.
  - `hi_len = (div_cur+1)>>1`, so odd N gives one extra high cycle.
- `clk_out` is 1 in exactly the cycles where state is RUN/STOP and `cnt < hi_len`; otherwise 0. It is registered, computed from next-state values.
- `tick` is 1 in the cycle where `cnt == 0` in RUN/STOP.
- State transitions:
  - IDLE to RUN: `run_en` sampled 1. Next cycle `cnt=0`, `clk_out=1`, `tick=1`.
  - RUN to STOP: `run_en` sampled 0 in a non-wrap cycle.
  - RUN to IDLE directly: `run_en` sampled 0 on a wrap cycle.
  - STOP to RUN: `run_en` sampled 1 again. The period continues, with no gap and no counter reset.
  - STOP to IDLE: wrap cycle. `clk_out` stays low and `cnt` returns to 0.
- Config handshake:
  - Transfer when `cfg_valid && cfg_ready`.
  - `cfg_ready = !pend`.
  - Ratio < 2 is rejected: `cfg_err` pulses the following cycle and no state changes.
  - Accept in IDLE: `div_cur` is updated the next cycle.
  - Accept in RUN/STOP: `div_pend` is loaded and `pend` is set.
  - At the next wrap, `div_cur <= div_pend` and `pend` clears. The new period then starts with `cnt=0` under the new ratio.
  - Accept on a wrap cycle: the new ratio is applied at that same wrap and `pend` is never set.
- Simultaneous events:
  - Accept plus IDLE-to-RUN in the same cycle: the first period uses the new ratio.
  - Pending ratio plus the STOP-to-IDLE wrap: the ratio is still applied, and `div_cur` holds it while idle.
- Reset asserted mid-operation: every register returns to its reset value immediately, and a pending ratio is discarded.

## Timing
- Reset values:
  - state IDLE, `cnt=0`, `div_cur=DEFAULT_DIV`, `pend=0`.
  - `clk_out=0`, `tick=0`, `cfg_err=0`, `busy=0`, `cfg_ready=1`.
- Start latency: one cycle from `run_en` sampled high to the first `clk_out`/`tick` high.
- Stop latency: `clk_out` falls no earlier than the end of the current high phase. The last period is always complete.
- Ratio change takes effect at most `div_cur` cycles after acceptance. There is never a truncated or stretched period.
- `cfg_err` and `tick` are single-cycle, registered.

## Structure
- Package `clkdiv_pkg` holds:
  - state enum (IDLE, RUN, STOP);
  - `DIV_MIN = 2`;
  - the default ratio constants for 2 MHz (8) and 1 MHz (16).
- Sub-module `clkdiv_period_cnt` holds the counter, the wrap detect and the `hi_len` compare. Its inputs are `div_cur` and an enable; its outputs are `cnt`, `wrap` and `hi`.
- The top level holds the FSM, the config handshake and the output registers.

## Test plan
- Reset with `DEFAULT_DIV=8`, then `run_en=1` -> `clk_out` toggles 4 high / 4 low (2 MHz), and `tick` fires every 8 cycles starting one cycle after `run_en`.
- Accept `cfg_div=16` mid-period while running at 8 -> `cfg_ready` low until the wrap. Period 8 completes, then 8 high / 8 low, with no glitch.
- `cfg_div=5` -> pattern is 3 high / 2 low, with `tick` every 5 cycles.
- `cfg_div=1` and `cfg_div=0` -> `cfg_err` pulses for one cycle, and `div_cur`, `pend` and `clk_out` are unchanged.
- Drop `run_en` at `cnt=2` with div 8 -> period completes through `cnt=7`, then IDLE with `clk_out=0`. Reassert at `cnt=5` instead -> period continues seamlessly.
- Assert `reset` during PEND in RUN -> all outputs at reset values that same cycle. After release, `div_cur=DEFAULT_DIV`.
